// File: rtl/scan_sched_ctrl.sv
// Depth-first scheduler for a scan-style polar decoder: channel load, then F/G/LEAF/BOTTOM sequencing.
// Optional stall input is enabled by defining SCAN_SCHED_STALL_EN.
module scan_sched_ctrl #(
    parameter int N = 1024,
    parameter int P = 128
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SCAN_SCHED_STALL_EN
    input  logic        stall,
`endif
    input  logic        start,
    input  logic        channel_ready,
    output logic        busy,
    output logic        done,
    output logic        channel,
    output logic [5:0]  channel_count,
    output logic [3:0]  op_type,
    output logic [3:0]  op_type_next,
    output logic [10:0] I_Nv,
    output logic [10:0] I_Nv_next,
    output logic [4:0]  counter,
    output logic [4:0]  counter_next,
    output logic [9:0]  address1,
    output logic [9:0]  address1_next,
    output logic [12:0] O_bit_count
);

    typedef enum logic [1:0] {IDLE, LOAD, DECODE} state_t;

    localparam logic [3:0]  OP_F      = 4'b0000;
    localparam logic [3:0]  OP_G      = 4'b0001;
    localparam logic [3:0]  OP_BOTTOM = 4'b0010;
    localparam logic [3:0]  OP_LEAF   = 4'b0011;
    localparam logic [3:0]  OP_NOP    = 4'b1111;
    localparam int          SHIFT     = $clog2(2 * P);
    localparam logic [10:0] SIZE_N    = 11'(N);
    localparam logic [12:0] BITS_N    = 13'(N);
    localparam logic [5:0]  LAST_WORD = 6'(N / P - 1);

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic [5:0]  cc_q, cc_d;
    logic [3:0]  op_q, op_d;
    logic [10:0] size_q, size_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [9:0]  addr_q, addr_d;
    logic [12:0] obc_q, obc_d;

    logic        stall_act;
    logic [10:0] dur;
    logic [10:0] half;
    logic [10:0] dbl;
    logic        last_cycle;
    logic        frame_end;
    logic [3:0]  succ_op;
    logic [10:0] succ_size;
    logic [9:0]  succ_addr;
    logic [12:0] obc_inc;

`ifdef SCAN_SCHED_STALL_EN
    assign stall_act = stall && (state_q != IDLE);
`else
    assign stall_act = 1'b0;
`endif

    // Successor of the current operation in the depth-first tree walk.
    always_comb begin
        dur        = size_q >> SHIFT;
        if (dur == 11'd0) dur = 11'd1;
        last_cycle = ({6'd0, cnt_q} == (dur - 11'd1));
        half       = size_q >> 1;
        dbl        = size_q << 1;
        frame_end  = 1'b0;
        succ_op    = OP_NOP;
        succ_size  = 11'd0;
        succ_addr  = 10'd0;
        case (op_q)
            OP_F, OP_G: begin
                succ_op   = (half > 11'd2) ? OP_F : OP_LEAF;
                succ_size = half;
                succ_addr = {addr_q[8:0], (op_q == OP_G)};
            end
            OP_LEAF, OP_BOTTOM: begin
                succ_size = dbl;
                succ_addr = addr_q >> 1;
                if (!addr_q[0]) begin
                    succ_op = OP_G;
                end else if (dbl == SIZE_N) begin
                    frame_end = 1'b1;
                end else begin
                    succ_op = OP_BOTTOM;
                end
            end
            default: frame_end = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        cc_d    = cc_q;
        op_d    = op_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        obc_d   = obc_q;
        obc_inc = obc_q + 13'd2;
        if (!stall_act) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        cc_d    = 6'd0;
                        obc_d   = 13'd0;
                    end
                end
                LOAD: begin
                    if (channel_ready) begin
                        if (cc_q == LAST_WORD) begin
                            state_d = DECODE;
                            cc_d    = 6'd0;
                            op_d    = OP_F;
                            size_d  = SIZE_N;
                            cnt_d   = 5'd0;
                            addr_d  = 10'd0;
                        end else begin
                            cc_d = cc_q + 6'd1;
                        end
                    end
                end
                DECODE: begin
                    if (op_q == OP_LEAF) obc_d = (obc_inc >= BITS_N) ? BITS_N : obc_inc;
                    if (!last_cycle) begin
                        cnt_d = cnt_q + 5'd1;
                    end else if (frame_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        op_d    = OP_NOP;
                        size_d  = 11'd0;
                        cnt_d   = 5'd0;
                        addr_d  = 10'd0;
                    end else begin
                        op_d   = succ_op;
                        size_d = succ_size;
                        cnt_d  = 5'd0;
                        addr_d = succ_addr;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            cc_q    <= 6'd0;
            op_q    <= OP_NOP;
            size_q  <= 11'd0;
            cnt_q   <= 5'd0;
            addr_q  <= 10'd0;
            obc_q   <= 13'd0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cc_q    <= cc_d;
            op_q    <= op_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            obc_q   <= obc_d;
        end
    end

    // Outside DECODE the look-ahead advertises the first operation of the next frame.
    always_comb begin
        if (stall_act && (state_q == DECODE)) begin
            op_type_next  = op_q;
            I_Nv_next     = size_q;
            counter_next  = cnt_q;
            address1_next = addr_q;
        end else if (state_q != DECODE) begin
            op_type_next  = OP_F;
            I_Nv_next     = SIZE_N;
            counter_next  = 5'd0;
            address1_next = 10'd0;
        end else begin
            op_type_next  = op_d;
            I_Nv_next     = size_d;
            counter_next  = cnt_d;
            address1_next = addr_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign channel       = (state_q == DECODE);
    assign channel_count = cc_q;
    assign op_type       = op_q;
    assign I_Nv          = size_q;
    assign counter       = cnt_q;
    assign address1      = addr_q;
    assign O_bit_count   = obc_q;

endmodule

// File: tb/tb_scan_sched_ctrl.sv
// Self-checking bench for scan_sched_ctrl: randomized load gaps and start noise, checked against
// an explicit-stack depth-first walk of the decode tree.
module tb_scan_sched_ctrl;

    localparam int N = 1024;
    localparam int P = 128;
    localparam logic [3:0] OP_F = 4'b0000, OP_G = 4'b0001, OP_BOTTOM = 4'b0010,
                           OP_LEAF = 4'b0011, OP_NOP = 4'b1111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        channel_ready = 1'b0;
`ifdef SCAN_SCHED_STALL_EN
    logic        stall = 1'b0;
`endif
    logic        busy, done, channel;
    logic [5:0]  channel_count;
    logic [3:0]  op_type, op_type_next;
    logic [10:0] I_Nv, I_Nv_next;
    logic [4:0]  counter, counter_next;
    logic [9:0]  address1, address1_next;
    logic [12:0] O_bit_count;

    int compared = 0;
    int mismatched = 0;
    int dec_cycles = 0;
    int done_pulses = 0;
    int obc_exp = 0;
    logic [29:0] cyc_q[$];

    int stk_s[32];
    int stk_a[32];
    int stk_ph[32];

    scan_sched_ctrl #(.N(N), .P(P)) dut (
        .clk(clk), .rst(rst),
`ifdef SCAN_SCHED_STALL_EN
        .stall(stall),
`endif
        .start(start), .channel_ready(channel_ready),
        .busy(busy), .done(done), .channel(channel), .channel_count(channel_count),
        .op_type(op_type), .op_type_next(op_type_next),
        .I_Nv(I_Nv), .I_Nv_next(I_Nv_next),
        .counter(counter), .counter_next(counter_next),
        .address1(address1), .address1_next(address1_next),
        .O_bit_count(O_bit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (channel) dec_cycles <= dec_cycles + 1;
        if (done) done_pulses <= done_pulses + 1;
    end

    function automatic logic [29:0] mk(input logic [3:0] op, input int sz, input int cnt, input int a);
        logic [10:0] s11 = sz[10:0];
        logic [4:0]  c5  = cnt[4:0];
        logic [9:0]  a10 = a[9:0];
        return {op, s11, c5, a10};
    endfunction

    function automatic logic [29:0] cur_vec();
        return {op_type, I_Nv, counter, address1};
    endfunction

    function automatic logic [29:0] next_vec();
        return {op_type_next, I_Nv_next, counter_next, address1_next};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic emit(input logic [3:0] op, input int s, input int a);
        int d = s / (2 * P);
        if (d < 1) d = 1;
        for (int c = 0; c < d; c++) cyc_q.push_back(mk(op, s, c, a));
    endtask

    // Recursive visit(s,a): F, left subtree, G, right subtree, BOTTOM (root has no BOTTOM).
    task automatic build_model();
        int sp = 1;
        cyc_q.delete();
        stk_s[0] = N; stk_a[0] = 0; stk_ph[0] = 0;
        while (sp > 0) begin
            int s = stk_s[sp-1];
            int a = stk_a[sp-1];
            if (s == 2) begin
                emit(OP_LEAF, 2, a);
                sp--;
            end else if (stk_ph[sp-1] == 0) begin
                emit(OP_F, s, a);
                stk_ph[sp-1] = 1;
                stk_s[sp] = s / 2; stk_a[sp] = 2 * a; stk_ph[sp] = 0; sp++;
            end else if (stk_ph[sp-1] == 1) begin
                emit(OP_G, s, a);
                stk_ph[sp-1] = 2;
                stk_s[sp] = s / 2; stk_a[sp] = 2 * a + 1; stk_ph[sp] = 0; sp++;
            end else begin
                if (s != N) emit(OP_BOTTOM, s, a);
                sp--;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_flags"}, {61'd0, busy, done, channel}, 64'd0);
        checkOutput({tag, "_cc"}, 64'(channel_count), 64'd0);
        checkOutput({tag, "_cur"}, 64'(cur_vec()), 64'(mk(OP_NOP, 0, 0, 0)));
        checkOutput({tag, "_nxt"}, 64'(next_vec()), 64'(mk(OP_F, N, 0, 0)));
        checkOutput({tag, "_obits"}, 64'(O_bit_count), 64'd0);
    endtask

    // Starts a frame in the current IDLE cycle and feeds N/P words with random gaps.
    task automatic applyStimulus();
        int words = N / P;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("load_flags", {61'd0, busy, done, channel}, 64'b100);
        checkOutput("load_cc0", 64'(channel_count), 64'd0);
        checkOutput("load_nxt", 64'(next_vec()), 64'(mk(OP_F, N, 0, 0)));
        for (int w = 0; w < words; w++) begin
            int gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                channel_ready = 1'b0;
                start = 1'($urandom % 2);
                tick();
                checkOutput("load_gap_cc", 64'(channel_count), 64'(w));
            end
            start = 1'b0;
            channel_ready = 1'b1;
            tick();
            channel_ready = 1'b0;
            if (w < words - 1) checkOutput("load_cc", 64'(channel_count), 64'(w + 1));
            else checkOutput("load_end_chan", 64'(channel), 64'd1);
        end
        obc_exp = 0;
    endtask

    task automatic walk(input int ncyc, input bit rand_start, input bit do_stall);
        for (int i = 0; i < ncyc; i++) begin
`ifdef SCAN_SCHED_STALL_EN
            if (do_stall && i == 4) begin
                stall = 1'b1;
                #1;
                checkOutput("stall_nxt_eq_cur", 64'(next_vec()), 64'(cur_vec()));
                for (int k = 0; k < 10; k++) begin
                    tick();
                    checkOutput("stall_cur", 64'(cur_vec()), 64'(cyc_q[4]));
                    checkOutput("stall_nxt", 64'(next_vec()), 64'(cyc_q[4]));
                    checkOutput("stall_obits", 64'(O_bit_count), 64'(obc_exp));
                end
                stall = 1'b0;
                #1;
            end
`else
            if (do_stall && i == 4) checkOutput("nostall_cur", 64'(cur_vec()), 64'(cyc_q[4]));
`endif
            checkOutput("dec_cur", 64'(cur_vec()), 64'(cyc_q[i]));
            checkOutput("dec_nxt", 64'(next_vec()),
                        64'((i + 1 < cyc_q.size()) ? cyc_q[i+1] : mk(OP_NOP, 0, 0, 0)));
            checkOutput("dec_flags", {61'd0, busy, done, channel}, 64'b101);
            checkOutput("dec_obits", 64'(O_bit_count), 64'(obc_exp));
            if (i == 14) checkOutput("after_leaf0", 64'(cur_vec()), 64'(mk(OP_G, 4, 0, 0)));
            if (i == 16) checkOutput("after_leaf1", 64'(cur_vec()), 64'(mk(OP_BOTTOM, 4, 0, 0)));
            if (i == 2054) checkOutput("last_op_c0", 64'(cur_vec()), 64'(mk(OP_BOTTOM, 512, 0, 1)));
            if (i == 2055) checkOutput("last_op_c1", 64'(cur_vec()), 64'(mk(OP_BOTTOM, 512, 1, 1)));
            if (cyc_q[i][29:26] == OP_LEAF) obc_exp = (obc_exp + 2 > N) ? N : obc_exp + 2;
            start = rand_start ? 1'($urandom % 2) : 1'b0;
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        int base;
        build_model();
        checkOutput("model_len", 64'(cyc_q.size()), 64'd2056);

        #2 rst = 1'b0;
        #1 check_reset_state("reset");
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            channel_ready = 1'b1;
            tick();
            checkOutput("idle_ready_ignored", 64'(channel_count), 64'd0);
        end
        channel_ready = 1'b0;
        check_reset_state("idle");

        // Frame 1: full decode with start noise while busy.
        base = dec_cycles;
        applyStimulus();
        walk(2056, 1'b1, 1'b0);
        checkOutput("f1_done", {61'd0, busy, done, channel}, 64'b010);
        checkOutput("f1_obits", 64'(O_bit_count), 64'(N));
        checkOutput("f1_cur", 64'(cur_vec()), 64'(mk(OP_NOP, 0, 0, 0)));
        checkOutput("f1_len", 64'(dec_cycles - base), 64'd2056);

        // Frame 2: start coincident with done, reset at decode cycle 700.
        applyStimulus();
        checkOutput("f2_obits_clr", 64'(O_bit_count), 64'd0);
        walk(700, 1'b1, 1'b0);
        rst = 1'b0;
        #1 check_reset_state("midrst");
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("post_rst_flags", {61'd0, busy, done, channel}, 64'd0);
        end
        checkOutput("done_count_f2", 64'(done_pulses), 64'd1);

        // Frame 3: fresh full frame, stalled mid-F(512,0) when the stall port exists.
        base = dec_cycles;
        applyStimulus();
        walk(2056, 1'b0, 1'b1);
        checkOutput("f3_done", {61'd0, busy, done, channel}, 64'b010);
        checkOutput("f3_obits", 64'(O_bit_count), 64'(N));
`ifdef SCAN_SCHED_STALL_EN
        checkOutput("f3_len", 64'(dec_cycles - base), 64'd2066);
`else
        checkOutput("f3_len", 64'(dec_cycles - base), 64'd2056);
`endif
        tick();
        checkOutput("f3_done_pulse", {61'd0, busy, done, channel}, 64'd0);
        checkOutput("f3_obits_hold", 64'(O_bit_count), 64'(N));
        checkOutput("done_count_f3", 64'(done_pulses), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
